moore_seq_detect: RTL and testbench

- Parametrised Moore-type serial pattern detector.
- Successor to the fixed 2-bit, 4-state Moore FSM: the pattern, its length, overlap mode and the match counter width are all parameters.
- Samples a 1-bit serial input on qualified clock edges and tracks the current match length as its state.
- Drives a registered Moore output and a saturating match counter for use by downstream control or test logic.

---
 rtl/moore_seq_detect.sv | 110 +++++++++++
 tb/tb_moore_seq_detect.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/moore_seq_detect.sv
// Moore serial pattern detector with a parametric pattern, length and overlap mode.
// The state is the current match length; a saturating counter tracks completed matches.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   0          | no leading pattern bits matched
//   1..PAT_W-1 | that many leading pattern bits matched
//   PAT_W      | full pattern seen; z is high
//   >PAT_W     | unreachable; returns to 0 on the next enabled edge
module moore_seq_detect #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8,
    localparam int              ST_W    = $clog2(PAT_W + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic             x,
    output logic             z,
    output logic [ST_W-1:0]  state,
    output logic [CNT_W-1:0] match_cnt,
    output logic             sat
);

    localparam logic [ST_W-1:0] K_FULL = ST_W'(PAT_W);

    // Bit k of the mask is set when the first j-1 pattern bits equal the last
    // j-1 of the first k pattern bits, i.e. a j-bit match can survive from state k.
    function automatic logic [PAT_W:0] border_mask(input int j);
        logic [PAT_W:0] m;
        bit             ok;
        m = '0;
        for (int k = 0; k <= PAT_W; k++) begin
            ok = (k >= j - 1);
            if (ok) begin
                for (int i = 0; i < j - 1; i++) begin
                    if (PATTERN[PAT_W-1-i] != PATTERN[PAT_W-1-(k-j+1+i)])
                        ok = 1'b0;
                end
            end
            m[k] = ok;
        end
        return m;
    endfunction

    logic [ST_W-1:0]  k_eff;
    logic [PAT_W:1]   cand;
    logic [ST_W-1:0]  fb;
    logic [ST_W-1:0]  state_nxt;
    logic             z_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_nxt;
    logic             sat_nxt;

    // Non-overlap mode treats a completed match as if nothing had been seen.
    always_comb begin
        k_eff = state;
        if (state > K_FULL || (state == K_FULL && !OVERLAP))
            k_eff = '0;
    end

    for (genvar j = 1; j <= PAT_W; j++) begin : g_cand
        localparam logic [PAT_W:0] MASK = border_mask(j);
        assign cand[j] = (x == PATTERN[PAT_W-j]) && MASK[k_eff];
    end

    always_comb begin
        fb = '0;
        for (int j = 1; j <= PAT_W; j++) begin
            if (cand[j])
                fb = ST_W'(j);
        end
    end

    assign cnt_inc = match_cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = match_cnt;
        sat_nxt   = sat;
        if (en)
            state_nxt = (state > K_FULL) ? '0 : fb;
        z_nxt = (state_nxt == K_FULL);
        if (clear) begin
            cnt_nxt = '0;
            sat_nxt = 1'b0;
        end else if (en && state_nxt == K_FULL && !(&match_cnt)) begin
            cnt_nxt = cnt_inc;
            sat_nxt = &cnt_inc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= '0;
            z         <= 1'b0;
            match_cnt <= '0;
            sat       <= 1'b0;
        end else begin
            state     <= state_nxt;
            z         <= z_nxt;
            match_cnt <= cnt_nxt;
            sat       <= sat_nxt;
        end
    end

endmodule

// File: tb/tb_moore_seq_detect.sv
// Bench for moore_seq_detect: four parameterisations driven in parallel and
// checked every cycle against a history-based model, plus directed sequences.
module tb_moore_seq_detect;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       en    = 1'b0;
    logic       clear = 1'b0;
    logic       x     = 1'b0;

    logic       z_ov, z_no, z_alt, z_sat;
    logic [2:0] st_ov, st_no, st_alt, st_sat;
    logic [7:0] cnt_ov, cnt_no;
    logic [3:0] cnt_alt;
    logic [1:0] cnt_sat;
    logic       sat_ov, sat_no, sat_alt, sat_sat;

    always #5 clock = ~clock;

    moore_seq_detect #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
        .clock(clock), .reset(reset), .en(en), .clear(clear), .x(x),
        .z(z_ov), .state(st_ov), .match_cnt(cnt_ov), .sat(sat_ov));

    moore_seq_detect #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_no (
        .clock(clock), .reset(reset), .en(en), .clear(clear), .x(x),
        .z(z_no), .state(st_no), .match_cnt(cnt_no), .sat(sat_no));

    moore_seq_detect #(.PAT_W(5), .PATTERN(5'b10010), .OVERLAP(1'b1), .CNT_W(4)) u_alt (
        .clock(clock), .reset(reset), .en(en), .clear(clear), .x(x),
        .z(z_alt), .state(st_alt), .match_cnt(cnt_alt), .sat(sat_alt));

    moore_seq_detect #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
        .clock(clock), .reset(reset), .en(en), .clear(clear), .x(x),
        .z(z_sat), .state(st_sat), .match_cnt(cnt_sat), .sat(sat_sat));

    int          n_vec = 0;
    int          n_err = 0;

    int          pw[4]   = '{4, 4, 5, 4};
    logic [15:0] pat[4]  = '{16'b1011, 16'b1011, 16'b10010, 16'b1011};
    bit          ov[4]   = '{1'b1, 1'b0, 1'b1, 1'b1};
    int          cmax[4] = '{255, 255, 15, 3};
    bit          hist[4][$];
    int          mk[4];
    int          mcnt[4];
    bit          msat[4];

    // Longest suffix of the received bits that equals a prefix of the pattern.
    function automatic int longest(input logic [15:0] p, input int n, input bit h[$]);
        int sz;
        sz = h.size();
        for (int j = (sz < n) ? sz : n; j > 0; j--) begin
            bit ok;
            ok = 1'b1;
            for (int i = 0; i < j; i++)
                if (h[sz-j+i] != p[n-1-i]) ok = 1'b0;
            if (ok) return j;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit e, input bit c, input bit b);
        for (int i = 0; i < 4; i++) begin
            if (r) begin
                hist[i].delete();
                mk[i]   = 0;
                mcnt[i] = 0;
                msat[i] = 1'b0;
            end else begin
                if (e) begin
                    if (!ov[i] && mk[i] == pw[i]) hist[i].delete();
                    hist[i].push_back(b);
                    if (hist[i].size() > pw[i]) void'(hist[i].pop_front());
                    mk[i] = longest(pat[i], pw[i], hist[i]);
                end
                if (c) begin
                    mcnt[i] = 0;
                    msat[i] = 1'b0;
                end else if (e && mk[i] == pw[i] && mcnt[i] < cmax[i]) begin
                    mcnt[i]++;
                    if (mcnt[i] == cmax[i]) msat[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("ov.state",  st_ov,   mk[0]);
        chk("ov.z",      z_ov,    mk[0] == pw[0]);
        chk("ov.cnt",    cnt_ov,  mcnt[0]);
        chk("ov.sat",    sat_ov,  msat[0]);
        chk("no.state",  st_no,   mk[1]);
        chk("no.z",      z_no,    mk[1] == pw[1]);
        chk("no.cnt",    cnt_no,  mcnt[1]);
        chk("no.sat",    sat_no,  msat[1]);
        chk("alt.state", st_alt,  mk[2]);
        chk("alt.z",     z_alt,   mk[2] == pw[2]);
        chk("alt.cnt",   cnt_alt, mcnt[2]);
        chk("alt.sat",   sat_alt, msat[2]);
        chk("sat.state", st_sat,  mk[3]);
        chk("sat.z",     z_sat,   mk[3] == pw[3]);
        chk("sat.cnt",   cnt_sat, mcnt[3]);
        chk("sat.sat",   sat_sat, msat[3]);
    endtask

    task automatic step(input bit r, input bit e, input bit c, input bit b);
        reset = r;
        en    = e;
        clear = c;
        x     = b;
        @(posedge clock);
        model_update(r, e, c, b);
        #1;
        check_all();
    endtask

    task automatic feed(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--)
            step(1'b0, 1'b1, 1'b0, bits[i]);
    endtask

    initial begin
        logic [6:0]  s_ovl;
        logic [4:0]  s_fb;
        logic [15:0] s_rep;
        int          e_ov[7];
        int          e_no[7];
        int          e_fb[5];

        s_ovl = 7'b1011011;
        s_fb  = 5'b11011;
        s_rep = 16'b1011011011011011;
        e_ov  = '{1, 2, 3, 4, 2, 3, 4};
        e_no  = '{1, 2, 3, 4, 0, 1, 1};
        e_fb  = '{1, 1, 2, 3, 4};

        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst.state", st_ov, 0);
        chk("rst.z", z_ov, 0);
        chk("rst.cnt", cnt_ov, 0);

        // Overlap vs non-overlap on the same stream
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 1'b0, s_ovl[6-i]);
            chk("ovl.seq", st_ov, e_ov[i]);
            chk("nov.seq", st_no, e_no[i]);
            if (i == 3 || i == 6) chk("ovl.z", z_ov, 1);
        end
        chk("ovl.cnt", cnt_ov, 2);
        chk("nov.cnt", cnt_no, 1);
        chk("nov.z", z_no, 0);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, s_fb[4-i]);
            chk("fb.seq", st_ov, e_fb[i]);
        end
        chk("fb.z", z_ov, 1);

        // Enable gating
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, i[0]);
            chk("gate.hold", st_ov, 2);
        end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("gate.s3", st_ov, 3);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("gate.s4", st_ov, 4);
        chk("gate.cnt", cnt_ov, 1);

        // Reset mid-match, plus saturation on the narrow counter
        step(1'b1, 1'b0, 1'b0, 1'b0);
        feed({16'd0, s_rep}, 16);
        feed(32'b01, 2);
        chk("mid.state", st_ov, 3);
        chk("mid.cnt", cnt_ov, 5);
        chk("satc.cnt", cnt_sat, 3);
        chk("satc.sat", sat_sat, 1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("mid.rst.state", st_ov, 0);
        chk("mid.rst.z", z_ov, 0);
        chk("mid.rst.cnt", cnt_ov, 0);
        chk("mid.rst.sat", sat_sat, 0);
        feed(32'b1011, 4);
        chk("mid.again", cnt_ov, 1);

        // Clear on a completing edge wins over the increment
        step(1'b1, 1'b0, 1'b0, 1'b0);
        feed({16'd0, s_rep}, 16);
        feed(32'b01, 2);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("clr.state", st_sat, 4);
        chk("clr.z", z_sat, 1);
        chk("clr.cnt", cnt_sat, 0);
        chk("clr.sat", sat_sat, 0);

        // Randomised traffic against the model
        for (int n = 0; n < 2000; n++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 49) == 0,
                 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
